// File: rtl/mdu_radix_if.sv
// rtl/mdu_radix_if.sv - execute-stage request/result bundle for the radix multiply/divide unit
interface mdu_radix_if #(
  parameter int W = 32
);
  logic         s_stall_i;
  logic         s_flush_i;
  logic         s_compute_i;
  logic [2:0]   s_function_i;
  logic [W-1:0] s_operand1_i;
  logic [W-1:0] s_operand2_i;
  logic         s_finished_o;
  logic [W-1:0] s_result_o;

  modport master (
    output s_stall_i, s_flush_i, s_compute_i, s_function_i, s_operand1_i, s_operand2_i,
    input  s_finished_o, s_result_o
  );

  modport slave (
    input  s_stall_i, s_flush_i, s_compute_i, s_function_i, s_operand1_i, s_operand2_i,
    output s_finished_o, s_result_o
  );
endinterface

// File: rtl/mdu_radix.sv
// rtl/mdu_radix.sv - iterative radix-2^STEP multiply/divide unit with division fast path
// Operands are latched as magnitudes; signs are reapplied when the result is loaded.
module mdu_radix #(
  parameter int W    = 32,
  parameter int STEP = 1
) (
  input  logic      s_clk_i,
  input  logic      s_resetn_i,
  mdu_radix_if.slave bus
);

  localparam int N  = W / STEP;
  localparam int CW = $clog2(N);
  localparam int XW = W + STEP;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [2:0]     fn_q;
  logic           neg_q;
  logic           rneg_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   opnd_q;
  logic [W-1:0]   shift_q;
  logic [W:0]     upper_q;
  logic [W-1:0]   result_q;
  logic           finished_q;

  logic [2:0]     fn;
  logic [W-1:0]   op1, op2;
  logic           sgn1, sgn2, neg1, neg2;
  logic [W-1:0]   mag1, mag2;
  logic           is_div, is_rem, div_zero, div_ovf, special;
  logic [W-1:0]   fast_res;

  logic [XW-1:0]  mul_sum;
  logic [W:0]     div_r;
  logic [W-1:0]   div_q;
  logic [W:0]     upper_d;
  logic [W-1:0]   shift_d;
  logic [2*W-1:0] product, prod_s;
  logic [W-1:0]   quot_s, rem_s, calc_res;

  logic           accept, load_fast, load_calc;

  // Request decode and division special cases, evaluated on the live operands.
  always_comb begin
    fn       = bus.s_function_i;
    op1      = bus.s_operand1_i;
    op2      = bus.s_operand2_i;
    sgn1     = (fn == 3'b001) || (fn == 3'b010) || (fn == 3'b100) || (fn == 3'b110);
    sgn2     = (fn == 3'b001) || (fn == 3'b100) || (fn == 3'b110);
    neg1     = sgn1 && op1[W-1];
    neg2     = sgn2 && op2[W-1];
    mag1     = neg1 ? -op1 : op1;
    mag2     = neg2 ? -op2 : op2;
    is_div   = fn[2];
    is_rem   = fn[1];
    div_zero = is_div && (op2 == '0);
    div_ovf  = is_div && !fn[0] && (op1 == {1'b1, {(W-1){1'b0}}}) && (&op2);
    special  = div_zero || div_ovf;
    if (div_zero)
      fast_res = is_rem ? op1 : '1;
    else
      fast_res = is_rem ? '0 : op1;
  end

  // One iteration: STEP shift-add stages or STEP restoring-division stages.
  always_comb begin
    mul_sum = {{STEP{1'b0}}, upper_q[W-1:0]};
    for (int j = 0; j < STEP; j++) begin
      if (shift_q[j])
        mul_sum = mul_sum + (XW'(opnd_q) << j);
    end

    div_r = upper_q;
    div_q = shift_q;
    for (int j = 0; j < STEP; j++) begin
      div_r = {div_r[W-1:0], div_q[W-1]};
      div_q = {div_q[W-2:0], 1'b0};
      if (div_r >= {1'b0, opnd_q}) begin
        div_r    = div_r - {1'b0, opnd_q};
        div_q[0] = 1'b1;
      end
    end

    if (fn_q[2]) begin
      upper_d = div_r;
      shift_d = div_q;
    end else begin
      upper_d = {1'b0, mul_sum[XW-1:STEP]};
      shift_d = {mul_sum[STEP-1:0], shift_q[W-1:STEP]};
    end

    product = {mul_sum, shift_q[W-1:STEP]};
    prod_s  = neg_q ? -product : product;
    quot_s  = neg_q ? -div_q : div_q;
    rem_s   = rneg_q ? -div_r[W-1:0] : div_r[W-1:0];

    case (fn_q)
      3'b000:         calc_res = prod_s[W-1:0];
      3'b100, 3'b101: calc_res = quot_s;
      3'b110, 3'b111: calc_res = rem_s;
      default:        calc_res = prod_s[2*W-1:W];
    endcase
  end

  // Flush outranks every transition, including acceptance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.s_flush_i && bus.s_compute_i)
          state_d = special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (bus.s_flush_i || !bus.s_compute_i)
          state_d = S_IDLE;
        else if (cnt_q == LAST)
          state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.s_flush_i || !bus.s_stall_i)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    accept    = (state_q == S_IDLE) && (state_d != S_IDLE);
    load_fast = (state_q == S_IDLE) && (state_d == S_DONE);
    load_calc = (state_q == S_CALC) && (state_d == S_DONE);
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      fn_q       <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      cnt_q      <= '0;
      opnd_q     <= '0;
      shift_q    <= '0;
      upper_q    <= '0;
      result_q   <= '0;
      finished_q <= 1'b0;
    end else begin
      if (accept) begin
        fn_q    <= fn;
        neg_q   <= neg1 ^ neg2;
        rneg_q  <= neg1;
        cnt_q   <= '0;
        opnd_q  <= is_div ? mag2 : mag1;
        shift_q <= is_div ? mag1 : mag2;
        upper_q <= '0;
      end else if (state_q == S_CALC) begin
        cnt_q   <= cnt_q + 1'b1;
        upper_q <= upper_d;
        shift_q <= shift_d;
      end

      if (load_fast)
        result_q <= fast_res;
      else if (load_calc)
        result_q <= calc_res;

      finished_q <= (state_d == S_DONE);
    end
  end

  assign bus.s_finished_o = finished_q;
  assign bus.s_result_o   = result_q;

endmodule

// File: tb/tb_mdu_radix.sv
// tb/tb_mdu_radix.sv - directed-vector bench for mdu_radix at STEP 1, 2 and 4 (W=32)
module tb_mdu_radix;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, compute;
  logic [2:0]  fn;
  logic [31:0] op1, op2;
  logic [1:0]  sel;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  mdu_radix_if #(.W(32)) if0 ();
  mdu_radix_if #(.W(32)) if1 ();
  mdu_radix_if #(.W(32)) if2 ();

  assign if0.s_stall_i    = stall;
  assign if0.s_flush_i    = flush;
  assign if0.s_compute_i  = compute && (sel == 2'd0);
  assign if0.s_function_i = fn;
  assign if0.s_operand1_i = op1;
  assign if0.s_operand2_i = op2;
  assign if1.s_stall_i    = stall;
  assign if1.s_flush_i    = flush;
  assign if1.s_compute_i  = compute && (sel == 2'd1);
  assign if1.s_function_i = fn;
  assign if1.s_operand1_i = op1;
  assign if1.s_operand2_i = op2;
  assign if2.s_stall_i    = stall;
  assign if2.s_flush_i    = flush;
  assign if2.s_compute_i  = compute && (sel == 2'd2);
  assign if2.s_function_i = fn;
  assign if2.s_operand1_i = op1;
  assign if2.s_operand2_i = op2;

  mdu_radix #(.W(32), .STEP(1)) u_step1 (.s_clk_i(clk), .s_resetn_i(rst_n), .bus(if0.slave));
  mdu_radix #(.W(32), .STEP(2)) u_step2 (.s_clk_i(clk), .s_resetn_i(rst_n), .bus(if1.slave));
  mdu_radix #(.W(32), .STEP(4)) u_step4 (.s_clk_i(clk), .s_resetn_i(rst_n), .bus(if2.slave));

  logic        fin;
  logic [31:0] res;
  assign fin = (sel == 2'd0) ? if0.s_finished_o : (sel == 2'd1) ? if1.s_finished_o : if2.s_finished_o;
  assign res = (sel == 2'd0) ? if0.s_result_o   : (sel == 2'd1) ? if1.s_result_o   : if2.s_result_o;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives a request and counts cycles until finished; compute is left high.
  task automatic issue(input logic [1:0] k, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input int exp_cyc, input logic [31:0] exp_res,
                       input string tag);
    int cyc;
    sel = k; fn = f; op1 = a; op2 = b; compute = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      step();
      cyc++;
      if (fin) break;
    end
    check({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_res"}, res, exp_res);
  endtask

  task automatic release_op(input string tag);
    step();
    compute = 1'b0;
    check({tag, "_idle"}, {31'd0, fin}, 32'd0);
  endtask

  task automatic run(input logic [1:0] k, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input int exp_cyc, input logic [31:0] exp_res,
                     input string tag);
    issue(k, f, a, b, exp_cyc, exp_res, tag);
    release_op(tag);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; compute = 1'b0;
    fn = 3'b000; op1 = '0; op2 = '0; sel = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_fin_s1", {31'd0, if0.s_finished_o}, 32'd0);
    check("rst_res_s1", if0.s_result_o, 32'd0);
    check("rst_fin_s2", {31'd0, if1.s_finished_o}, 32'd0);
    check("rst_res_s4", if2.s_result_o, 32'd0);
    rst_n = 1'b1;
    step();

    run(2'd1, F_MUL,    32'd7,        32'hFFFFFFFD, 17, 32'hFFFFFFEB, "mul_s2");
    run(2'd0, F_MULH,   32'h80000000, 32'h80000000, 33, 32'h40000000, "mulh_s1");
    run(2'd0, F_MULHU,  32'h80000000, 32'h80000000, 33, 32'h40000000, "mulhu_s1");
    run(2'd0, F_MULHSU, 32'hFFFFFFFF, 32'd2,        33, 32'hFFFFFFFF, "mulhsu_s1");
    run(2'd2, F_MULH,   32'hFFFFFFFF, 32'd1,        9,  32'hFFFFFFFF, "mulh_s4");

    run(2'd2, F_DIV,  32'hFFFFFFF9, 32'd2,        9, 32'hFFFFFFFD, "div_m7_2");
    run(2'd2, F_REM,  32'hFFFFFFF9, 32'd2,        9, 32'hFFFFFFFF, "rem_m7_2");
    run(2'd2, F_DIVU, 32'd100,      32'd7,        9, 32'd14,       "divu_100_7");
    run(2'd2, F_REMU, 32'd100,      32'd7,        9, 32'd2,        "remu_100_7");
    run(2'd2, F_DIV,  32'd7,        32'hFFFFFFFE, 9, 32'hFFFFFFFD, "div_7_m2");
    run(2'd2, F_REM,  32'd7,        32'hFFFFFFFE, 9, 32'd1,        "rem_7_m2");
    run(2'd2, F_DIVU, 32'hFFFFFFFF, 32'd1,        9, 32'hFFFFFFFF, "divu_max_1");
    run(2'd2, F_DIVU, 32'h80000000, 32'hFFFFFFFF, 9, 32'd0,        "divu_nospecial");

    run(2'd2, F_DIV,  32'd5,        32'd0,        1, 32'hFFFFFFFF, "div_by0");
    run(2'd2, F_REM,  32'd5,        32'd0,        1, 32'd5,        "rem_by0");
    run(2'd2, F_DIVU, 32'd5,        32'd0,        1, 32'hFFFFFFFF, "divu_by0");
    run(2'd2, F_DIV,  32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, "div_ovf");
    run(2'd2, F_REM,  32'h80000000, 32'hFFFFFFFF, 1, 32'd0,        "rem_ovf");

    // Stalled result for 3 DONE cycles, then a back-to-back MUL.
    stall = 1'b1;
    issue(2'd2, F_DIVU, 32'd100, 32'd7, 9, 32'd14, "stall_divu");
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_fin", {31'd0, fin}, 32'd1);
      check("stall_res", res, 32'd14);
    end
    stall = 1'b0;
    step();
    check("stall_release", {31'd0, fin}, 32'd0);
    run(2'd2, F_MUL, 32'd3, 32'd4, 9, 32'd12, "b2b_mul");

    // Dropping compute mid-CALC abandons the operation.
    sel = 2'd2; fn = F_DIVU; op1 = 32'd100; op2 = 32'd7; compute = 1'b1;
    repeat (3) step();
    compute = 1'b0;
    seen = 0;
    repeat (12) begin step(); if (fin) seen++; end
    check("drop_no_fin", 32'(seen), 32'd0);

    // Flush in CALC iteration 5; a fast request right after must be taken from IDLE.
    sel = 2'd2; fn = F_DIVU; op1 = 32'd100; op2 = 32'd7; compute = 1'b1;
    seen = 0;
    repeat (5) begin step(); if (fin) seen++; end
    flush = 1'b1;
    step();
    if (fin) seen++;
    flush = 1'b0;
    check("flush_no_fin", 32'(seen), 32'd0);
    run(2'd2, F_DIV, 32'd5, 32'd0, 1, 32'hFFFFFFFF, "post_flush");

    // Flush coincident with a fast-path request blocks acceptance.
    sel = 2'd2; fn = F_REM; op1 = 32'd9; op2 = 32'd0; compute = 1'b1; flush = 1'b1;
    seen = 0;
    repeat (3) begin step(); if (fin) seen++; end
    check("flush_req_no_fin", 32'(seen), 32'd0);
    check("flush_req_res", res, 32'hFFFFFFFF);
    compute = 1'b0; flush = 1'b0;
    step();

    // Reset mid-CALC clears outputs asynchronously.
    run(2'd2, F_MUL, 32'd3, 32'd4, 9, 32'd12, "pre_rst_mul");
    sel = 2'd2; fn = F_DIVU; op1 = 32'd100; op2 = 32'd7; compute = 1'b1;
    repeat (3) step();
    check("calc_hold_res", res, 32'd12);
    rst_n = 1'b0;
    #1;
    check("rst_mid_fin", {31'd0, fin}, 32'd0);
    check("rst_mid_res", res, 32'd0);
    compute = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_after_fin", {31'd0, fin}, 32'd0);
    run(2'd2, F_DIVU, 32'd9, 32'd3, 9, 32'd3, "divu_9_3");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_radix.md
# mdu_radix

Parametrised iterative multiply/divide unit for the execute stage. It is the successor of the fixed single-rate MDU. The width and the number of result bits retired per cycle are configurable, and division special cases take a fast path. It receives operands and the M-extension function from the execute stage, holds its result across MA-stage stalls, and aborts on flush.

## Interface
Parameters:
- W, 32: operand/result width; power of two, ≥ 8.
- STEP, 1: bits retired per iteration; power of two, divides W, STEP ≤ W/2.

Ports:
- s_clk_i  in  1  clock; all state changes on the rising edge.
- s_resetn_i  in  1  reset; asynchronous, active-low.
- s_stall_i  in  1  MA stage stall; DONE is held while high.
- s_flush_i  in  1  pipeline flush; aborts any operation.
- s_compute_i  in  1  request; upstream holds it high until the result is consumed.
- s_function_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- s_operand1_i  in  W  rs1 (multiplicand or dividend).
- s_operand2_i  in  W  rs2 (multiplier or divisor).
- s_finished_o  out  1  result valid; registered.
- s_result_o  out  W  result; registered.

## Operation
- N = W/STEP iterations.
- States:
  - IDLE → CALC: s_compute_i=1 and s_flush_i=0.
  - IDLE → DONE: s_compute_i=1, s_flush_i=0, and a division special case applies.
  - CALC → DONE: iteration counter reaches N-1.
  - DONE → IDLE: s_stall_i=0.
- Acceptance (IDLE):
  - Latch the function.
  - Latch operand magnitudes. An operand is treated as signed per function: MULH both; MULHSU rs1 only; DIV and REM both; all others unsigned.
  - Latch the result-sign flags.
  - Clear the counter; set the counter width to clog2(N).
- Multiply (CALC): radix-2^STEP shift-add. Each cycle adds the multiplicand × the low STEP multiplier bits into a 2W accumulator, then shifts the accumulator right by STEP.
- Divide (CALC): restoring division. Each cycle produces STEP quotient bits into the W-bit quotient and updates the W+1-bit partial remainder.
- Entry to DONE loads s_result_o:
  - MUL: product[W-1:0].
  - MULH, MULHSU, MULHU: product[2W-1:W]. The 2W product is negated when the signs differ.
  - DIV, DIVU: the quotient, negated when the operand signs differ.
  - REM, REMU: the remainder, carrying the sign of the dividend.
- Special cases (division only, fast path, no CALC):
  - Divisor 0: quotient all-ones; remainder equals the dividend.
  - Signed overflow (dividend = -2^(W-1), divisor = -1): quotient equals the dividend; remainder 0.
- s_finished_o is 1 exactly while in DONE.
- s_result_o keeps its last value outside DONE and is only meaningful while s_finished_o=1.
- Abort: s_flush_i=1, or s_compute_i=0 while in CALC, sends the unit to IDLE on the next edge. Partial results are discarded and s_finished_o stays 0.
- Flush has priority over every other transition, including a request arriving in IDLE.
- Reset: state IDLE, s_finished_o=0, s_result_o=0, counter 0. Asserting reset mid-operation drops the operation with no residue.

## Timing
- Cycle 0: request seen in IDLE.
- Cycles 1..N: CALC.
- Cycle N+1: DONE, s_finished_o=1.
- Fast path: DONE in cycle 1.
- Stall in DONE: s_finished_o and s_result_o are held constant for every stalled cycle.
- Consumption: the first DONE cycle with s_stall_i=0. The unit returns to IDLE on the following edge.
- Back-to-back: a new request that is high in the first IDLE cycle after DONE is accepted. There is one bubble cycle between results.
- Throughput: one operation every N+2 cycles.
- Combinational paths: none from inputs to outputs.
- Critical path: a STEP-deep adder chain per iteration.

## Test plan
- W=32, STEP=2, MUL 7 × -3 → s_finished_o rises in cycle 17; result 0xFFFFFFEB.
- W=32, STEP=1, MULH 0x80000000 × 0x80000000 → finished in cycle 33; result 0x40000000. MULHU with the same operands → 0x40000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- W=32, STEP=4:
  - DIV -7 / 2 → 0xFFFFFFFD in cycle 9.
  - REM -7 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- Special cases, all finishing in cycle 1:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / -1 → 0x80000000.
  - REM 0x80000000 / -1 → 0.
- DIVU 100 / 7 with s_stall_i=1 for 3 DONE cycles → finished and result 14 held for 4 cycles, then IDLE. A new MUL 3 × 4 issued immediately after → 12.
- Aborts and reset:
  - s_flush_i pulsed in CALC iteration 5 → IDLE next edge, finished never rises.
  - Flush coincident with a request in IDLE → no acceptance.
  - s_resetn_i low mid-CALC → outputs 0 immediately.
  - After reset release, a fresh DIVU 9 / 3 → 3.
